// File: rtl/target_pattern_gen.sv
// Sensor-side stimulus generator: drives the targeting lock-on sequence and the 101 abort code.
// Optional fire_in monitor (fire_seen / fire_late) is built when FIRE_CHECK_EN is defined.
module target_pattern_gen #(
   parameter int unsigned GAP_W = 4,
   parameter int unsigned DLY_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [GAP_W-1:0] gap_cycles,
   input  logic [DLY_W-1:0] hit1_dly,
   input  logic [DLY_W-1:0] hit2_dly,
   input  logic             abort,
   output logic [2:0]       sensor_out,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             aborted
`ifdef FIRE_CHECK_EN
   ,
   input  logic             fire_in,
   output logic             fire_seen,
   output logic             fire_late
`endif
);

   localparam int unsigned CNT_W = (GAP_W > DLY_W) ? GAP_W : DLY_W;

   localparam logic [2:0] SYM_IDLE  = 3'b000;
   localparam logic [2:0] SYM_CAL   = 3'b111;
   localparam logic [2:0] SYM_LEFT  = 3'b001;
   localparam logic [2:0] SYM_RIGHT = 3'b010;
   localparam logic [2:0] SYM_HIT   = 3'b100;
   localparam logic [2:0] SYM_ABORT = 3'b101;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CAL1   = 4'd1,
      S_CAL2   = 4'd2,
      S_LEFT   = 4'd3,
      S_GAP    = 4'd4,
      S_RIGHT  = 4'd5,
      S_SETTLE = 4'd6,
      S_WAIT1  = 4'd7,
      S_HIT1   = 4'd8,
      S_WAIT2  = 4'd9,
      S_HIT2   = 4'd10,
      S_FIN    = 4'd11,
      S_ABORT  = 4'd12
   } state_e;

   state_e           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [DLY_W-1:0] hit1_q, hit1_d;
   logic [DLY_W-1:0] hit2_q, hit2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       sensor_out_q, sensor_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             accept_c;
   logic             abortable_c;

   // Next-state, config latch, delay counter and registered-output decode
   always_comb begin
      state_d      = state_q;
      gap_d        = gap_q;
      hit1_d       = hit1_q;
      hit2_d       = hit2_q;
      cnt_d        = cnt_q;
      accept_c     = 1'b0;
      abortable_c  = 1'b0;
      sensor_out_d = SYM_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      aborted_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               accept_c = 1'b1;
               gap_d    = gap_cycles;
               hit1_d   = hit1_dly;
               hit2_d   = hit2_dly;
               state_d  = S_CAL1;
            end
         end
         S_CAL1: state_d = S_CAL2;
         S_CAL2: state_d = S_LEFT;
         S_LEFT: begin
            if (gap_q != '0) begin
               state_d = S_GAP;
               cnt_d   = CNT_W'(gap_q) - CNT_W'(1);
            end else begin
               state_d = S_RIGHT;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_RIGHT;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_RIGHT: state_d = S_SETTLE;
         S_SETTLE: begin
            if (hit1_q != '0) begin
               state_d = S_WAIT1;
               cnt_d   = CNT_W'(hit1_q) - CNT_W'(1);
            end else begin
               state_d = S_HIT1;
            end
         end
         S_WAIT1: begin
            if (cnt_q == '0) state_d = S_HIT1;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_HIT1: begin
            if (hit2_q != '0) begin
               state_d = S_WAIT2;
               cnt_d   = CNT_W'(hit2_q) - CNT_W'(1);
            end else begin
               state_d = S_HIT2;
            end
         end
         S_WAIT2: begin
            if (cnt_q == '0) state_d = S_HIT2;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_HIT2:  state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort wins over normal progress, but only while a sequence is on the bus
      abortable_c = (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_ABORT);
      if (abortable_c && abort) begin
         state_d = S_ABORT;
         cnt_d   = '0;
      end

      case (state_d)
         S_CAL1, S_CAL2:  sensor_out_d = SYM_CAL;
         S_LEFT:          sensor_out_d = SYM_LEFT;
         S_RIGHT:         sensor_out_d = SYM_RIGHT;
         S_HIT1, S_HIT2:  sensor_out_d = SYM_HIT;
         S_ABORT:         sensor_out_d = SYM_ABORT;
         default:         sensor_out_d = SYM_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d    = (state_d == S_FIN);
      aborted_d = (state_q == S_ABORT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         gap_q        <= '0;
         hit1_q       <= '0;
         hit2_q       <= '0;
         cnt_q        <= '0;
         sensor_out_q <= SYM_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         hit1_q       <= hit1_d;
         hit2_q       <= hit2_d;
         cnt_q        <= cnt_d;
         sensor_out_q <= sensor_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
      end
   end

   assign sensor_out = sensor_out_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign ready      = (state_q == S_IDLE);

`ifdef FIRE_CHECK_EN
   logic [1:0] win_q, win_d;
   logic       fire_seen_q, fire_seen_d;
   logic       fire_late_q, fire_late_d;
   logic       win_act_c;

   // Legal fire window spans FIN and the two cycles after it; win_q counts the tail
   always_comb begin
      win_d       = win_q;
      fire_seen_d = fire_seen_q;
      fire_late_d = fire_late_q;
      win_act_c   = (state_q == S_FIN) || (win_q != 2'd0);

      if (state_q == S_FIN)    win_d = 2'd2;
      else if (win_q != 2'd0)  win_d = win_q - 2'd1;

      if (accept_c) begin
         win_d       = 2'd0;
         fire_seen_d = 1'b0;
         fire_late_d = 1'b0;
      end else if (fire_in) begin
         if (win_act_c)   fire_seen_d = 1'b1;
         else if (busy_q) fire_late_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q       <= 2'd0;
         fire_seen_q <= 1'b0;
         fire_late_q <= 1'b0;
      end else begin
         win_q       <= win_d;
         fire_seen_q <= fire_seen_d;
         fire_late_q <= fire_late_d;
      end
   end

   assign fire_seen = fire_seen_q;
   assign fire_late = fire_late_q;
`endif

endmodule
